// File: rtl/spi_frame_dispatcher.sv
// Byte-stream to atomic RGBW parameter set: framed bytes fill shadow registers and commit together.
// Optional FRAME_CHECKSUM_EN adds a trailing XOR checksum byte verified before commit.
module spi_frame_dispatcher #(
    parameter logic [7:0]  START_BYTE = 8'hA5,
    parameter int unsigned TO_W       = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic [7:0] data,
    input  logic       cs,
    output logic [7:0] mode_sync,
    output logic [7:0] lint_sync,
    output logic [7:0] colorIdx_sync,
    output logic [7:0] red_sync,
    output logic [7:0] green_sync,
    output logic [7:0] blue_sync,
    output logic [7:0] white_sync,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_CHECK   = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd6;

    state_t          state_r;
    state_t          next_state_s;
    logic            rdy_q_r;
    logic            strobe_s;
    logic            shadow_we_s;
    logic            to_expired_s;
    logic [2:0]      idx_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [7:0]      shadow_r [0:6];

`ifdef FRAME_CHECKSUM_EN
    function automatic logic [7:0] frame_xor(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic [7:0] b4, input logic [7:0] b5,
                                             input logic [7:0] b6);
        frame_xor = b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6;
    endfunction
`endif

    assign strobe_s     = rdy & ~rdy_q_r;
    assign to_expired_s = (to_cnt_r == {TO_W{1'b1}});

    // Next-state decode; a strobe is always consumed before cs or timeout are considered
    always_comb begin
        next_state_s = state_r;
        shadow_we_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (strobe_s && (data == START_BYTE) && !cs) begin
                    next_state_s = ST_PAYLOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (strobe_s) begin
                    shadow_we_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
`ifdef FRAME_CHECKSUM_EN
                        if (cs) begin
                            next_state_s = ST_ABORT;
                        end else begin
                            next_state_s = ST_CHECK;
                        end
`else
                        next_state_s = ST_COMMIT;
`endif
                    end else if (cs) begin
                        next_state_s = ST_ABORT;
                    end else begin
                        next_state_s = ST_PAYLOAD;
                    end
                end else if (cs || to_expired_s) begin
                    next_state_s = ST_ABORT;
                end else begin
                    next_state_s = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
`ifdef FRAME_CHECKSUM_EN
                if (strobe_s) begin
                    if (data == frame_xor(shadow_r[0], shadow_r[1], shadow_r[2], shadow_r[3],
                                          shadow_r[4], shadow_r[5], shadow_r[6])) begin
                        next_state_s = ST_COMMIT;
                    end else begin
                        next_state_s = ST_ABORT;
                    end
                end else if (cs || to_expired_s) begin
                    next_state_s = ST_ABORT;
                end else begin
                    next_state_s = ST_CHECK;
                end
`else
                next_state_s = ST_IDLE;
`endif
            end
            ST_COMMIT: next_state_s = ST_IDLE;
            ST_ABORT:  next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // rdy edge detector and state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdy_q_r <= 1'b0;
            state_r <= ST_IDLE;
        end else begin
            rdy_q_r <= rdy;
            state_r <= next_state_s;
        end
    end

    // Payload index and shadow capture; index rests at zero outside PAYLOAD
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_r <= 3'd0;
            for (int i = 0; i < 7; i++) begin
                shadow_r[i] <= 8'h00;
            end
        end else begin
            if (state_r != ST_PAYLOAD) begin
                idx_r <= 3'd0;
            end else if (shadow_we_s) begin
                idx_r <= idx_r + 3'd1;
            end
            for (int i = 0; i < 7; i++) begin
                if (shadow_we_s && (idx_r == 3'(i))) begin
                    shadow_r[i] <= data;
                end
            end
        end
    end

    // Inter-byte timeout: cleared by any strobe, counts only while a frame is open
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (strobe_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == ST_PAYLOAD) || (state_r == ST_CHECK)) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Committed outputs, status pulses and saturating abort counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_sync     <= 8'h00;
            lint_sync     <= 8'h00;
            colorIdx_sync <= 8'h00;
            red_sync      <= 8'h00;
            green_sync    <= 8'h00;
            blue_sync     <= 8'h00;
            white_sync    <= 8'h00;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
            err_cnt       <= 8'h00;
        end else begin
            frame_ok  <= (state_r == ST_COMMIT);
            frame_err <= (state_r == ST_ABORT);
            if (state_r == ST_COMMIT) begin
                mode_sync     <= shadow_r[0];
                lint_sync     <= shadow_r[1];
                colorIdx_sync <= shadow_r[2];
                red_sync      <= shadow_r[3];
                green_sync    <= shadow_r[4];
                blue_sync     <= shadow_r[5];
                white_sync    <= shadow_r[6];
            end
            if ((state_r == ST_ABORT) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_dispatcher.sv
// Directed, table-driven bench for spi_frame_dispatcher plus hand sequences for timing corners.
module tb_spi_frame_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       rdy;
    logic [7:0] data;
    logic       cs;
    logic [7:0] mode_sync, lint_sync, colorIdx_sync, red_sync, green_sync, blue_sync, white_sync;
    logic       frame_ok, frame_err;
    logic [7:0] err_cnt;

    spi_frame_dispatcher dut (
        .clk(clk), .reset(reset), .rdy(rdy), .data(data), .cs(cs),
        .mode_sync(mode_sync), .lint_sync(lint_sync), .colorIdx_sync(colorIdx_sync),
        .red_sync(red_sync), .green_sync(green_sync), .blue_sync(blue_sync),
        .white_sync(white_sync), .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      n_lead;
        logic [15:0]     lead;
        logic [6:0][7:0] pay;
        int              n_pay;
        bit              bad_chk;
        int              exp_ok;
        int              exp_err;
        logic [7:0]      exp_errcnt;
    } vec_t;

    vec_t vecs [6];

    int checks = 0;
    int failures = 0;
    int ok_pulses = 0;
    int err_pulses = 0;
    int both_high = 0;
    int wide_pulses = 0;
    logic ok_prev = 1'b0;
    logic err_prev = 1'b0;
    logic [55:0] exp_out;
    logic [7:0]  exp_ec;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_ok) ok_pulses <= ok_pulses + 1;
        if (frame_err) err_pulses <= err_pulses + 1;
        if (frame_ok && frame_err) both_high <= both_high + 1;
        if ((frame_ok && ok_prev) || (frame_err && err_prev)) wide_pulses <= wide_pulses + 1;
        ok_prev  <= frame_ok;
        err_prev <= frame_err;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0][7:0] mkp(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3,
                                            input logic [7:0] b4, input logic [7:0] b5,
                                            input logic [7:0] b6);
        logic [6:0][7:0] p;
        p[0] = b0; p[1] = b1; p[2] = b2; p[3] = b3; p[4] = b4; p[5] = b5; p[6] = b6;
        return p;
    endfunction

    function automatic vec_t mkv(input logic [1:0] n_lead, input logic [15:0] lead,
                                 input logic [6:0][7:0] pay, input int n_pay, input bit bad_chk,
                                 input int exp_ok, input int exp_err, input logic [7:0] exp_errcnt);
        vec_t v;
        v.n_lead = n_lead; v.lead = lead; v.pay = pay; v.n_pay = n_pay; v.bad_chk = bad_chk;
        v.exp_ok = exp_ok; v.exp_err = exp_err; v.exp_errcnt = exp_errcnt;
        return v;
    endfunction

    function automatic logic [7:0] xor7(input logic [6:0][7:0] p);
        return p[0] ^ p[1] ^ p[2] ^ p[3] ^ p[4] ^ p[5] ^ p[6];
    endfunction

    function automatic logic [55:0] pack_pay(input logic [6:0][7:0] p);
        return {p[0], p[1], p[2], p[3], p[4], p[5], p[6]};
    endfunction

    function automatic logic [55:0] outs();
        return {mode_sync, lint_sync, colorIdx_sync, red_sync, green_sync, blue_sync, white_sync};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); data = b; rdy = 1'b1;
        @(negedge clk); rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < int'(v.n_lead); i++) send_byte(v.lead[i*8 +: 8]);
        send_byte(8'hA5);
        for (int i = 0; i < v.n_pay; i++) send_byte(v.pay[i]);
        if (v.n_pay < 7) begin
            @(negedge clk); cs = 1'b1;
            repeat (3) @(negedge clk);
            cs = 1'b0;
        end
`ifdef FRAME_CHECKSUM_EN
        else send_byte(xor7(v.pay) ^ {7'd0, v.bad_chk});
`endif
    endtask

    initial begin
        int ok0, e0, n;
        vec_t v;
        logic [6:0][7:0] p;
        reset = 1'b0; rdy = 1'b0; cs = 1'b1; data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {8'h00, outs()}, 64'h0);
        check("reset_err_cnt", {56'h0, err_cnt}, 64'h0);
        check("reset_pulses", {62'h0, frame_ok, frame_err}, 64'h0);
        reset = 1'b1; cs = 1'b0;
        exp_out = 56'h0;

        vecs[0] = mkv(2'd0, 16'h0000, mkp(8'h01, 8'h80, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40), 7, 1'b0, 1, 0, 8'd0);
        vecs[1] = mkv(2'd0, 16'h0000, mkp(8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00), 3, 1'b0, 0, 1, 8'd1);
        vecs[2] = mkv(2'd2, 16'hFF00, mkp(8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'hFF, 8'h00, 8'h81), 7, 1'b0, 1, 0, 8'd1);
        vecs[3] = mkv(2'd0, 16'h0000, mkp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 0, 1'b0, 0, 1, 8'd2);
`ifdef FRAME_CHECKSUM_EN
        vecs[4] = mkv(2'd0, 16'h0000, mkp(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07), 7, 1'b1, 0, 1, 8'd3);
        vecs[5] = mkv(2'd0, 16'h0000, mkp(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07), 7, 1'b0, 1, 0, 8'd3);
`else
        vecs[4] = mkv(2'd0, 16'h0000, mkp(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07), 7, 1'b1, 1, 0, 8'd2);
        vecs[5] = mkv(2'd0, 16'h0000, mkp(8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01), 7, 1'b0, 1, 0, 8'd2);
`endif

        for (int r = 0; r < 6; r++) begin
            ok0 = ok_pulses; e0 = err_pulses;
            send_frame(vecs[r]);
            repeat (4) @(negedge clk);
            if (vecs[r].exp_ok == 1) exp_out = pack_pay(vecs[r].pay);
            check($sformatf("row%0d_ok", r), 64'(ok_pulses - ok0), 64'(vecs[r].exp_ok));
            check($sformatf("row%0d_err", r), 64'(err_pulses - e0), 64'(vecs[r].exp_err));
            check($sformatf("row%0d_errcnt", r), {56'h0, err_cnt}, {56'h0, vecs[r].exp_errcnt});
            check($sformatf("row%0d_outs", r), {8'h00, outs()}, {8'h00, exp_out});
        end
        exp_ec = vecs[5].exp_errcnt;

        // Commit latency: outputs and frame_ok move on the second edge after the last strobe
        p = mkp(8'h21, 8'h42, 8'h63, 8'h84, 8'hA5, 8'hC6, 8'hE7);
        send_byte(8'hA5);
`ifdef FRAME_CHECKSUM_EN
        for (int i = 0; i < 7; i++) send_byte(p[i]);
        @(negedge clk); data = xor7(p); rdy = 1'b1;
`else
        for (int i = 0; i < 6; i++) send_byte(p[i]);
        @(negedge clk); data = p[6]; rdy = 1'b1;
`endif
        @(posedge clk); #1;
        check("lat_edge1_ok", {63'h0, frame_ok}, 64'h0);
        check("lat_edge1_outs", {8'h00, outs()}, {8'h00, exp_out});
        @(posedge clk); #1;
        exp_out = pack_pay(p);
        check("lat_edge2_ok", {63'h0, frame_ok}, 64'h1);
        check("lat_edge2_outs", {8'h00, outs()}, {8'h00, exp_out});
        @(posedge clk); #1;
        check("lat_edge3_ok", {63'h0, frame_ok}, 64'h0);
        @(negedge clk); rdy = 1'b0;
        repeat (3) @(negedge clk);

        // Inter-byte timeout after three payload bytes
        e0 = err_pulses;
        send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        n = 1;
        while (n < 5000) begin
            @(posedge clk); n++; #1;
            if (frame_err) break;
        end
        check("timeout_latency", 64'(n), 64'(4097));
        exp_ec = exp_ec + 8'd1;
        repeat (3) @(negedge clk);
        check("timeout_err_pulse", 64'(err_pulses - e0), 64'h1);
        check("timeout_errcnt", {56'h0, err_cnt}, {56'h0, exp_ec});
        check("timeout_outs_kept", {8'h00, outs()}, {8'h00, exp_out});
        v = mkv(2'd0, 16'h0, mkp(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10), 7, 1'b0, 1, 0, exp_ec);
        ok0 = ok_pulses;
        send_frame(v);
        repeat (4) @(negedge clk);
        exp_out = pack_pay(v.pay);
        check("post_timeout_ok", 64'(ok_pulses - ok0), 64'h1);
        check("post_timeout_outs", {8'h00, outs()}, {8'h00, exp_out});

        // cs rises in the same cycle as the final payload strobe
        p = mkp(8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37);
        ok0 = ok_pulses; e0 = err_pulses;
        send_byte(8'hA5);
        for (int i = 0; i < 6; i++) send_byte(p[i]);
        @(negedge clk); data = p[6]; rdy = 1'b1; cs = 1'b1;
        @(negedge clk); rdy = 1'b0;
        @(negedge clk); cs = 1'b0;
        repeat (4) @(negedge clk);
`ifdef FRAME_CHECKSUM_EN
        exp_ec = exp_ec + 8'd1;
        check("cs_last_ok", 64'(ok_pulses - ok0), 64'h0);
        check("cs_last_err", 64'(err_pulses - e0), 64'h1);
`else
        exp_out = pack_pay(p);
        check("cs_last_ok", 64'(ok_pulses - ok0), 64'h1);
        check("cs_last_err", 64'(err_pulses - e0), 64'h0);
`endif
        check("cs_last_outs", {8'h00, outs()}, {8'h00, exp_out});
        check("cs_last_errcnt", {56'h0, err_cnt}, {56'h0, exp_ec});

        // Reset mid-frame discards the partial frame silently
        ok0 = ok_pulses; e0 = err_pulses;
        send_byte(8'hA5); send_byte(8'h44); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_outs", {8'h00, outs()}, 64'h0);
        check("midreset_errcnt", {56'h0, err_cnt}, 64'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset_no_pulse", 64'((ok_pulses - ok0) + (err_pulses - e0)), 64'h0);
        v = mkv(2'd0, 16'h0, mkp(8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33), 7, 1'b0, 1, 0, 8'd0);
        send_frame(v);
        repeat (4) @(negedge clk);
        exp_out = pack_pay(v.pay);
        check("post_reset_ok", 64'(ok_pulses - ok0), 64'h1);
        check("post_reset_outs", {8'h00, outs()}, {8'h00, exp_out});
        check("post_reset_errcnt", {56'h0, err_cnt}, 64'h0);

        check("pulses_never_both", 64'(both_high), 64'h0);
        check("pulses_one_cycle", 64'(wide_pulses), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
